// File: rtl/color_demux_player.sv
// rtl/color_demux_player.sv - one-hot lamp player: lit for ON_CYCLES, dark for GAP_CYCLES, done pulse
module color_demux_player #(
    parameter int ON_CYCLES  = 25000000,
    parameter int GAP_CYCLES = 12500000,
    parameter int CNT_W      = 26
) (
    input  logic       CLK_i,
    input  logic       RSTN_i,
    input  logic       VALID_i,
    input  logic [1:0] SEL_i,
    input  logic       ABORT_i,
    output logic       READY_o,
    output logic [3:0] LED_o,
    output logic       BUSY_o,
    output logic       DONE_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Counter holds "cycles left minus one", so a phase ends on the edge where it reads zero.
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel_q;
    logic             done_q;
    logic             cnt_zero;
    logic             accept;

    assign cnt_zero = (cnt == '0);
    assign accept   = (state == S_IDLE) && VALID_i && !ABORT_i;

    // State register.
    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort outranks both acceptance and normal phase expiry.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = S_ON;
                end
            end
            S_ON: begin
                if (ABORT_i) begin
                    next_state = S_IDLE;
                end else if (cnt_zero) begin
                    next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (ABORT_i || cnt_zero) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Duration counter: reloaded on every state change, counts down to zero inside a phase.
    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            cnt <= '0;
        end else if (next_state != state) begin
            case (next_state)
                S_ON:    cnt <= ON_LOAD;
                S_GAP:   cnt <= GAP_LOAD;
                default: cnt <= '0;
            endcase
        end else if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Code capture on acceptance only, so SEL_i is ignored while playing.
    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            sel_q <= 2'b00;
        end else if (accept) begin
            sel_q <= SEL_i;
        end
    end

    // Done flag: set for the first IDLE cycle after a gap that ran to completion.
    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == S_GAP) && cnt_zero && !ABORT_i;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        READY_o = (state == S_IDLE);
        BUSY_o  = (state == S_ON) || (state == S_GAP);
        DONE_o  = done_q;
        LED_o   = 4'b0000;
        if (state == S_ON) begin
            LED_o = 4'b0001 << sel_q;
        end
    end

endmodule

// File: tb/tb_color_demux_player.sv
// tb/tb_color_demux_player.sv - scoreboard bench for color_demux_player
module tb_color_demux_player;

    localparam int ON_N  = 4;
    localparam int GAP_N = 2;

    logic       clk;
    logic       rstn;
    logic       valid;
    logic [1:0] sel;
    logic       abort_in;
    logic       ready;
    logic [3:0] led;
    logic       busy;
    logic       done;

    color_demux_player #(
        .ON_CYCLES (ON_N),
        .GAP_CYCLES(GAP_N),
        .CNT_W     (4)
    ) dut (
        .CLK_i  (clk),
        .RSTN_i (rstn),
        .VALID_i(valid),
        .SEL_i  (sel),
        .ABORT_i(abort_in),
        .READY_o(ready),
        .LED_o  (led),
        .BUSY_o (busy),
        .DONE_o (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    string phase = "init";

    // Reference model: 0 idle, 1 lit, 2 dark; rem = cycles remaining in phase.
    int       m_state = 0;
    int       m_rem = 0;
    int       m_sel = 0;
    logic     m_done = 1'b0;
    logic [6:0] exp_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [6:0] model_out();
        logic [3:0] l;
        l = (m_state == 1) ? (4'b0001 << m_sel) : 4'b0000;
        return {m_state == 0, m_state != 0, m_done, l};
    endfunction

    task automatic model_edge(input logic v, input logic [1:0] s, input logic a);
        m_done = 1'b0;
        case (m_state)
            0: if (v && !a) begin m_state = 1; m_rem = ON_N; m_sel = int'(s); end
            1: begin
                if (a) begin m_state = 0; end
                else begin
                    m_rem--;
                    if (m_rem == 0) begin m_state = 2; m_rem = GAP_N; end
                end
            end
            default: begin
                if (a) begin m_state = 0; end
                else begin
                    m_rem--;
                    if (m_rem == 0) begin m_state = 0; m_done = 1'b1; end
                end
            end
        endcase
    endtask

    task automatic compare_pending();
        logic [6:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(phase, {1'b0, ready, busy, done, led}, {1'b0, e});
            check("onehot", 8'($countones(led) <= 1), 8'd1);
            if (done === 1'b1) done_seen++;
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic a);
        @(negedge clk);
        compare_pending();
        valid = v;
        sel = s;
        abort_in = a;
        model_edge(v, s, a);
        exp_q.push_back(model_out());
    endtask

    task automatic mid_reset(input string tag);
        @(negedge clk);
        compare_pending();
        valid = 1'b0;
        abort_in = 1'b0;
        #1 rstn = 1'b0;
        #1 check(tag, {1'b0, ready, busy, done, led}, 8'b0100_0000);
        m_state = 0; m_rem = 0; m_sel = 0; m_done = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 check({tag, "_hold"}, {1'b0, ready, busy, done, led}, 8'b0100_0000);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        valid = 1'b0;
        sel = 2'b00;
        abort_in = 1'b0;
        #12;
        check("reset", {1'b0, ready, busy, done, led}, 8'b0100_0000);
        rstn = 1'b1;

        // Single play of code 10, accepted on the first edge after reset release.
        phase = "single";
        done_seen = 0;
        step(1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 2'b00, 1'b0);
        check("single_done_cnt", 8'(done_seen), 8'd1);

        // All four codes back-to-back with VALID held high.
        phase = "all_codes";
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'(k), 1'b0);
            for (int n = 0; n < 20 && m_state != 0; n++) step(1'b1, 2'(k), 1'b0);
        end
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        check("all_done_cnt", 8'(done_seen), 8'd4);

        // VALID and changing SEL while busy are ignored.
        phase = "ignore_busy";
        done_seen = 0;
        step(1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 2'($urandom_range(0, 3)), 1'b0);
        check("ignore_done_cnt", 8'(done_seen), 8'd1);

        // Abort in the second lit cycle, in the gap, and abort+valid in idle.
        phase = "abort";
        done_seen = 0;
        step(1'b1, 2'b11, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b10, 1'b1);
        step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        for (int n = 0; n < 10 && m_state != 2; n++) step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b0);
        check("abort_done_cnt", 8'(done_seen), 8'd0);

        // Asynchronous reset between edges, in the gap and while lit; then replay.
        phase = "async_reset";
        done_seen = 0;
        step(1'b1, 2'b01, 1'b0);
        for (int n = 0; n < 10 && m_state != 2; n++) step(1'b0, 2'b00, 1'b0);
        mid_reset("rst_in_gap");
        step(1'b1, 2'b11, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        mid_reset("rst_in_on");
        phase = "after_reset";
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 2'b00, 1'b0);
        check("reset_done_cnt", 8'(done_seen), 8'd1);

        @(negedge clk);
        compare_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_demux_player.md
COLOR_DEMUX_PLAYER -- requirements
Module: color_demux_player

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 25000000: clock cycles a selected lamp stays lit; legal range 1..2^CNT_W-1.
REQ-002 SHALL have parameter GAP_CYCLES, default 12500000: dark clock cycles after each lamp; legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 26: width of the internal duration counter.
REQ-004 SHALL have port CLK_i  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port RSTN_i  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port VALID_i  input  1  color code on SEL_i is offered for playback.
REQ-007 SHALL have port SEL_i  input  2  color code: 00 lamp 0, 01 lamp 1, 10 lamp 2, 11 lamp 3.
REQ-008 SHALL have port ABORT_i  input  1  cancel the current playback and return dark to IDLE.
REQ-009 SHALL have port READY_o  output  1  block can accept a code this cycle.
REQ-010 SHALL have port LED_o  output  4  one-hot lamp drive, bit n = lamp n.
REQ-011 SHALL have port BUSY_o  output  1  playback (ON or GAP) in progress.
REQ-012 SHALL have port DONE_o  output  1  one-cycle pulse: playback completed normally.

Function
REQ-013 SHALL implement FSM states IDLE, ON, GAP; one duration counter of CNT_W bits.
REQ-014 SHALL drive READY_o = 1 only in IDLE; BUSY_o = 1 only in ON or GAP.
REQ-015 SHALL accept a code on a rising edge where VALID_i=1 and READY_o=1 and ABORT_i=0; SEL_i captured into a register at that edge.
REQ-016 SHALL enter ON on the accepting edge; LED_o shows the decoded one-hot of the captured code in the first cycle after that edge (latency 1 cycle).
REQ-017 SHALL keep LED_o constant for exactly ON_CYCLES cycles; SEL_i changes during ON/GAP SHALL be ignored.
REQ-018 SHALL transition ON -> GAP after ON_CYCLES cycles; LED_o = 0000 in all GAP cycles.
REQ-019 SHALL transition GAP -> IDLE after exactly GAP_CYCLES cycles; DONE_o = 1 in the first IDLE cycle only.
REQ-020 SHALL accept a new code in that first IDLE cycle (DONE_o and acceptance may coincide), giving back-to-back playback with no extra idle cycle.
REQ-021 SHALL have at most one bit of LED_o set in any cycle; LED_o = 0000 in IDLE and GAP.
REQ-022 ABORT_i=1 in ON or GAP SHALL force IDLE at the next edge: LED_o = 0000, counter cleared, DONE_o stays 0.
REQ-023 ABORT_i=1 together with VALID_i=1 in IDLE SHALL take priority: no acceptance, state remains IDLE.
REQ-024 VALID_i=1 while READY_o=0 SHALL be ignored; no queuing, no effect on current playback.
REQ-025 SHALL reload the counter on every state entry; counter SHALL never wrap within a state.
REQ-026 All outputs SHALL be registered or decoded from registered state only; no combinational path from any input to any output.

Reset
REQ-027 RSTN_i=0 SHALL asynchronously force IDLE, counter 0, captured code 00, LED_o=0000, DONE_o=0, BUSY_o=0, READY_o=1.
REQ-028 Reset asserted mid-ON or mid-GAP SHALL extinguish LED_o immediately, without waiting for a clock edge, and produce no DONE_o pulse.
REQ-029 After RSTN_i deassertion the first accept SHALL be possible on the first rising edge with VALID_i=1.

Verification (ON_CYCLES=4, GAP_CYCLES=2)
REQ-030 Single play: VALID_i=1, SEL_i=10 for one cycle -> LED_o=0100 for 4 cycles, 0000 for 2 cycles, then DONE_o=1 for 1 cycle, READY_o=1.
REQ-031 All codes: play 00,01,10,11 back-to-back with VALID_i held high -> LED_o shows 0001,0010,0100,1000, each for 4 cycles, separated by 2 dark cycles; 4 DONE_o pulses.
REQ-032 Ignore while busy: SEL_i toggled and VALID_i=1 during ON -> LED_o unchanged, no extra playback after DONE_o.
REQ-033 Abort: ABORT_i=1 in 2nd ON cycle -> LED_o=0000 and READY_o=1 next cycle, DONE_o never pulses; ABORT_i+VALID_i in IDLE -> no acceptance.
REQ-034 Async reset: RSTN_i=0 between clock edges in GAP -> BUSY_o=0, READY_o=1 immediately; after release, a new code plays normally.
